// File: rtl/i_execute_pkg.sv
// Shared definitions for the EX stage: ALU op/funct codes, ALU control
// encodings, multiplier FSM states and the EX/MEM control payload.
package i_execute_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_MFHI = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO = 6'b010010;

  typedef enum logic [2:0] {
    ALUCTL_AND  = 3'd0,
    ALUCTL_OR   = 3'd1,
    ALUCTL_ADD  = 3'd2,
    ALUCTL_SUB  = 3'd3,
    ALUCTL_SLT  = 3'd4,
    ALUCTL_MFHI = 3'd5,
    ALUCTL_MFLO = 3'd6
  } aluctl_e;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_e;

  // Control bits carried through EX/MEM
  typedef struct packed {
    logic [1:0] wb;  // {regwrite, memtoreg}
    logic [2:0] m;   // {branch, memread, memwrite}
  } ex_ctl_t;

  // ALU control from aluop/funct; MULT and unknown functs fall back to add
  function automatic aluctl_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    aluctl_e ctl;
    ctl = ALUCTL_ADD;
    if (aluop == ALUOP_SUB) begin
      ctl = ALUCTL_SUB;
    end else if (aluop == ALUOP_FUNCT) begin
      case (funct)
        FUNCT_SUB:  ctl = ALUCTL_SUB;
        FUNCT_AND:  ctl = ALUCTL_AND;
        FUNCT_OR:   ctl = ALUCTL_OR;
        FUNCT_SLT:  ctl = ALUCTL_SLT;
        FUNCT_MFHI: ctl = ALUCTL_MFHI;
        FUNCT_MFLO: ctl = ALUCTL_MFLO;
        default:    ctl = ALUCTL_ADD;
      endcase
    end
    return ctl;
  endfunction

endpackage

// File: rtl/i_execute_mul.sv
// mul_seq: iterative signed shift-add multiplier owning HI/LO.
// Ports: clk, rst_n, start (load operands), a/b (signed operands),
// busy (FSM in BUSY), done (final iteration cycle), hi/lo (last product).
module mul_seq
  import i_execute_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned PROD_W = 2 * DATA_W;

  mul_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [PROD_W-1:0]   sum, prod;
  logic                last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next state: magnitudes multiplied unsigned, sign applied on the last step
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    abs_a    = a[DATA_W-1] ? DATA_W'(-a) : a;
    abs_b    = b[DATA_W-1] ? DATA_W'(-b) : b;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = neg_q ? PROD_W'(-sum) : sum;
    last     = (cnt_q == CNT_W'(DATA_W - 1));
    done     = 1'b0;

    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_BUSY;
          cnt_d    = '0;
          mcand_d  = PROD_W'(abs_a);
          mplier_d = abs_b;
          acc_d    = '0;
          neg_d    = a[DATA_W-1] ^ b[DATA_W-1];
        end
      end
      MUL_BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          done    = 1'b1;
          hi_d    = prod[PROD_W-1:DATA_W];
          lo_d    = prod[DATA_W-1:0];
          state_d = MUL_IDLE;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign busy = (state_q == MUL_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/i_execute.sv
// EX stage: ALU control, operand/destination muxes, branch-target adder,
// background multiplier with HI/LO, and the EX/MEM register.
// Inputs come from ID/EX (in_valid, flush, ctl bits, operands, specifiers);
// stall is combinational toward IF/ID and ID/EX; ex_* are the EX/MEM outputs.
module i_execute
  import i_execute_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              flush,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_ext,
  input  logic [REG_W-1:0]  instr_2016,
  input  logic [REG_W-1:0]  instr_1511,
  output logic              stall,
  output logic              ex_valid,
  output logic [1:0]        ex_wb_ctl,
  output logic [2:0]        ex_m_ctl,
  output logic [DATA_W-1:0] ex_add_result,
  output logic              ex_zero,
  output logic [DATA_W-1:0] ex_alu_result,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [REG_W-1:0]  ex_dest
);

  aluctl_e           aluctl;
  logic              is_mult, is_hilo, load, mul_start, mul_busy, mul_done_unused;
  logic [DATA_W-1:0] op_b, result, mul_hi, mul_lo;

  logic              ex_valid_q, ex_valid_d;
  ex_ctl_t           ex_ctl_q, ex_ctl_d;
  logic [DATA_W-1:0] ex_add_result_q, ex_add_result_d;
  logic              ex_zero_q, ex_zero_d;
  logic [DATA_W-1:0] ex_alu_result_q, ex_alu_result_d;
  logic [DATA_W-1:0] ex_rdata2_q, ex_rdata2_d;
  logic [REG_W-1:0]  ex_dest_q, ex_dest_d;

  mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (rdata1),
    .b     (rdata2),
    .busy  (mul_busy),
    .done  (mul_done_unused),
    .hi    (mul_hi),
    .lo    (mul_lo)
  );

  // Decode, hazard detection and result selection
  always_comb begin
    aluctl    = alu_decode(aluop, s_ext[5:0]);
    is_mult   = (aluop == ALUOP_FUNCT) && (s_ext[5:0] == FUNCT_MULT);
    is_hilo   = is_mult || (aluctl == ALUCTL_MFHI) || (aluctl == ALUCTL_MFLO);
    stall     = in_valid & is_hilo & mul_busy;
    load      = in_valid & ~flush & ~stall;
    mul_start = load & is_mult;
    op_b      = alusrc ? s_ext : rdata2;

    case (aluctl)
      ALUCTL_AND:  result = rdata1 & op_b;
      ALUCTL_OR:   result = rdata1 | op_b;
      ALUCTL_SUB:  result = rdata1 - op_b;
      ALUCTL_SLT:  result = DATA_W'($signed(rdata1) < $signed(op_b));
      ALUCTL_MFHI: result = mul_hi;
      ALUCTL_MFLO: result = mul_lo;
      default:     result = rdata1 + op_b;
    endcase

    // Datapath always loads; only valid/ctl are squashed for bubbles
    ex_valid_d      = load;
    ex_ctl_d        = '0;
    if (load) begin
      ex_ctl_d.wb = is_mult ? 2'b00 : wb_ctl;
      ex_ctl_d.m  = m_ctl;
    end
    ex_add_result_d = npc + (s_ext << 2);
    ex_alu_result_d = result;
    ex_zero_d       = (result == '0);
    ex_rdata2_d     = rdata2;
    ex_dest_d       = regdst ? instr_1511 : instr_2016;
  end

  // EX/MEM register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_ctl_q        <= '0;
      ex_add_result_q <= '0;
      ex_zero_q       <= 1'b0;
      ex_alu_result_q <= '0;
      ex_rdata2_q     <= '0;
      ex_dest_q       <= '0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_ctl_q        <= ex_ctl_d;
      ex_add_result_q <= ex_add_result_d;
      ex_zero_q       <= ex_zero_d;
      ex_alu_result_q <= ex_alu_result_d;
      ex_rdata2_q     <= ex_rdata2_d;
      ex_dest_q       <= ex_dest_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_wb_ctl     = ex_ctl_q.wb;
  assign ex_m_ctl      = ex_ctl_q.m;
  assign ex_add_result = ex_add_result_q;
  assign ex_zero       = ex_zero_q;
  assign ex_alu_result = ex_alu_result_q;
  assign ex_rdata2     = ex_rdata2_q;
  assign ex_dest       = ex_dest_q;

endmodule

// File: tb/tb_i_execute.sv
// Scoreboard bench for i_execute: directed instructions push expected EX/MEM
// contents; a negedge monitor pops and compares whenever ex_valid is high.
module tb_i_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, regdst, alusrc;
  logic [1:0]  wb_ctl, aluop;
  logic [2:0]  m_ctl;
  logic [31:0] npc, rdata1, rdata2, s_ext;
  logic [4:0]  instr_2016, instr_1511;
  logic        stall, ex_valid, ex_zero;
  logic [1:0]  ex_wb_ctl;
  logic [2:0]  ex_m_ctl;
  logic [31:0] ex_add_result, ex_alu_result, ex_rdata2;
  logic [4:0]  ex_dest;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] add;
    logic [31:0] rd2;
    logic [4:0]  dest;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] F_ADD  = 32'h20;
  localparam logic [31:0] F_SUB  = 32'h22;
  localparam logic [31:0] F_AND  = 32'h24;
  localparam logic [31:0] F_OR   = 32'h25;
  localparam logic [31:0] F_SLT  = 32'h2A;
  localparam logic [31:0] F_MULT = 32'h18;
  localparam logic [31:0] F_MFHI = 32'h10;
  localparam logic [31:0] F_MFLO = 32'h12;

  i_execute dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc),
    .aluop(aluop), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
    .s_ext(s_ext), .instr_2016(instr_2016), .instr_1511(instr_1511),
    .stall(stall), .ex_valid(ex_valid), .ex_wb_ctl(ex_wb_ctl),
    .ex_m_ctl(ex_m_ctl), .ex_add_result(ex_add_result), .ex_zero(ex_zero),
    .ex_alu_result(ex_alu_result), .ex_rdata2(ex_rdata2), .ex_dest(ex_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: EX/MEM outputs are stable at the falling edge
  always @(negedge clk) begin
    if (rst_n && ex_valid) begin
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: alu %h with empty scoreboard", ex_alu_result);
      end else begin
        e = exp_q.pop_front();
        if (ex_wb_ctl !== e.wb || ex_m_ctl !== e.m || ex_alu_result !== e.alu ||
            ex_zero !== e.zero || ex_add_result !== e.add || ex_rdata2 !== e.rd2 ||
            ex_dest !== e.dest) begin
          n_bad++;
          $display("FAIL exmem: got wb=%b m=%b alu=%h z=%b add=%h rd2=%h dst=%0d expected wb=%b m=%b alu=%h z=%b add=%h rd2=%h dst=%0d",
                   ex_wb_ctl, ex_m_ctl, ex_alu_result, ex_zero, ex_add_result, ex_rdata2, ex_dest,
                   e.wb, e.m, e.alu, e.zero, e.add, e.rd2, e.dest);
        end
      end
    end
  end

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic rd_sel,
                       input logic src, input logic [1:0] op, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic [4:0] rt_s, input logic [4:0] rd_s);
    wb_ctl = wb; m_ctl = m; regdst = rd_sel; alusrc = src; aluop = op;
    npc = pc4; rdata1 = rs; rdata2 = rt; s_ext = imm;
    instr_2016 = rt_s; instr_1511 = rd_s;
    in_valid = 1'b1; flush = 1'b0;
  endtask

  // Present one instruction, verify its stall duration, then expect it in EX/MEM
  task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic rd_sel,
                       input logic src, input logic [1:0] op, input logic [31:0] pc4,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic [4:0] rt_s, input logic [4:0] rd_s,
                       input logic [31:0] exp_alu, input logic [31:0] exp_add,
                       input int exp_stall);
    exp_t e;
    int   n;
    logic mult;
    drive(wb, m, rd_sel, src, op, pc4, rs, rt, imm, rt_s, rd_s);
    #1;
    n = 0;
    while (stall && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_cycles", 32'(n), 32'(exp_stall));
    mult   = (op == 2'b10) && (imm[5:0] == 6'h18);
    e.wb   = mult ? 2'b00 : wb;
    e.m    = m;
    e.alu  = exp_alu;
    e.zero = (exp_alu == 32'h0);
    e.add  = exp_add;
    e.rd2  = rt;
    e.dest = rd_sel ? rd_s : rt_s;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(ex_valid), 32'h0);
    check({tag, "_wb"}, 32'(ex_wb_ctl), 32'h0);
    check({tag, "_m"}, 32'(ex_m_ctl), 32'h0);
    check({tag, "_alu"}, ex_alu_result, 32'h0);
    check({tag, "_add"}, ex_add_result, 32'h0);
    check({tag, "_zero"}, 32'(ex_zero), 32'h0);
    check({tag, "_rd2"}, ex_rdata2, 32'h0);
    check({tag, "_dest"}, 32'(ex_dest), 32'h0);
    check({tag, "_stall"}, 32'(stall), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    in_valid = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: reset mid-multiply, then MFLO returns 0
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFD, 32'd7, F_MULT, 5'd2, 5'd3,
          32'd4, 32'h60, 0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFLO, 5'd0, 5'd4);
    #1;
    check("mflo_stalled", 32'(stall), 32'h1);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midmul_reset");
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFLO, 5'd0, 5'd4,
          32'h0, 32'h48, 0);

    // 2: R-type sub and slt
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7, F_SUB, 5'd7, 5'd9,
          32'hFFFFFFFE, 32'h88, 0);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd5, 32'd7, F_SLT, 5'd7, 5'd9,
          32'h1, 32'hA8, 0);
    // slt signed boundary: most negative < 1
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h80000000, 32'd1, F_SLT, 5'd1, 5'd10,
          32'h1, 32'hA8, 0);

    // 3: beq
    issue(2'b00, 3'b100, 1'b0, 1'b0, 2'b01, 32'h100, 32'd3, 32'd3, 32'd4, 5'd3, 5'd0,
          32'h0, 32'h110, 0);

    // 4: MULT then MFLO (stalls for all 32 busy cycles), then MFHI
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'hFFFFFFFD, 32'd7, F_MULT, 5'd2, 5'd3,
          32'd4, 32'h60, 0);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFLO, 5'd0, 5'd4,
          32'hFFFFFFEB, 32'h48, 32);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFHI, 5'd0, 5'd5,
          32'hFFFFFFFF, 32'h40, 0);

    // 5: MULT overlapped by independent ops, then HI/LO reads
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd6, 32'hFFFFFFFE, F_MULT, 5'd6, 5'd7,
          32'd4, 32'h60, 0);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h4, 32'd1, 32'd2, F_ADD, 5'd2, 5'd8,
          32'd3, 32'h84, 0);
    issue(2'b10, 3'b000, 1'b0, 1'b1, 2'b00, 32'h20, 32'd10, 32'd99, 32'hFFFFFFFF, 5'd11, 5'd31,
          32'd9, 32'h1C, 0);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0000F0F0, 32'h0000FF00, F_AND, 5'd1, 5'd12,
          32'h0000F000, 32'h90, 0);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0000F0F0, 32'h0000FF00, F_OR, 5'd1, 5'd13,
          32'h0000FFF0, 32'h94, 0);
    issue(2'b11, 3'b010, 1'b0, 1'b1, 2'b11, 32'h8, 32'hFFFFFFFF, 32'd0, 32'd1, 5'd14, 5'd0,
          32'h0, 32'hC, 0);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFHI, 5'd0, 5'd15,
          32'hFFFFFFFF, 32'h40, 27);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFLO, 5'd0, 5'd16,
          32'hFFFFFFF4, 32'h48, 0);

    // 6a: flushed MULT never starts; HI unchanged and no stall after
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd2, 32'd3, F_MULT, 5'd3, 5'd17);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_mult_valid", 32'(ex_valid), 32'h0);
    in_valid = 1'b0; flush = 1'b0;
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFHI, 5'd0, 5'd18,
          32'hFFFFFFFF, 32'h40, 0);

    // 6b: flush while MFHI is stalled keeps stall high and emits bubbles
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'd2, 32'd3, F_MULT, 5'd3, 5'd17,
          32'd5, 32'h60, 0);
    drive(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFHI, 5'd0, 5'd19);
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("flush_stall_valid", 32'(ex_valid), 32'h0);
      check("flush_stall_hold", 32'(stall), 32'h1);
    end
    flush = 1'b0;
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFHI, 5'd0, 5'd19,
          32'h0, 32'h40, 29);
    issue(2'b10, 3'b000, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, 32'h0, F_MFLO, 5'd0, 5'd20,
          32'd6, 32'h48, 0);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
